// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - byte-wide UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined)
// Two-flop synchroniser feeding a counter-timed FSM; all outputs are registered.
module uart_rx (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] cycles_per_databit,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_error,
  output logic       parity_error,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd5,
`endif
    BREAK  = 3'd4
  } state_t;

  state_t     state, state_nx;
  logic       sync1, rxs;
  logic [9:0] cnt, cnt_nx;
  logic [9:0] cpd, cpd_nx, cpd_in;
  logic [2:0] bit_idx, bit_idx_nx;
  logic [7:0] shreg, shreg_nx, rx_data_nx;
  logic       done_nx, ferr_nx, busy_nx;

  assign cpd_in = (cycles_per_databit < 10'd4) ? 10'd4 : cycles_per_databit;

`ifdef UART_RX_PARITY_EN
  logic par_flag, par_flag_nx, perr_nx;
`else
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1       <= 1'b1;
      rxs         <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      cpd         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
      rx_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_flag     <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      sync1       <= rx_line;
      rxs         <= sync1;
      state       <= state_nx;
      cnt         <= cnt_nx;
      cpd         <= cpd_nx;
      bit_idx     <= bit_idx_nx;
      shreg       <= shreg_nx;
      rx_data     <= rx_data_nx;
      rx_done     <= done_nx;
      frame_error <= ferr_nx;
      rx_busy     <= busy_nx;
`ifdef UART_RX_PARITY_EN
      par_flag     <= par_flag_nx;
      parity_error <= perr_nx;
`endif
    end
  end

  // A sample is acted on the edge after cnt reaches 0, hence the cpd-1 reloads.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    cpd_nx     = cpd;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    rx_data_nx = rx_data;
    done_nx    = 1'b0;
    ferr_nx    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_flag_nx = par_flag;
    perr_nx     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_nx = START;
          cpd_nx   = cpd_in;
          cnt_nx   = {1'b0, cpd_in[9:1]};
        end
      end
      START: begin
        if (cnt != 10'd0) begin
          cnt_nx = cnt - 10'd1;
        end else if (!rxs) begin
          state_nx   = DATA;
          bit_idx_nx = 3'd0;
          cnt_nx     = cpd - 10'd1;
        end else begin
          state_nx = IDLE;
        end
      end
      DATA: begin
        if (cnt != 10'd0) begin
          cnt_nx = cnt - 10'd1;
        end else begin
          shreg_nx   = {rxs, shreg[7:1]};
          cnt_nx     = cpd - 10'd1;
          bit_idx_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt != 10'd0) begin
          cnt_nx = cnt - 10'd1;
        end else begin
          par_flag_nx = rxs ^ (^shreg);
          cnt_nx      = cpd - 10'd1;
          state_nx    = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt != 10'd0) begin
          cnt_nx = cnt - 10'd1;
        end else begin
          rx_data_nx = shreg;
          if (rxs) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
`ifdef UART_RX_PARITY_EN
            perr_nx  = par_flag;
`endif
          end else begin
            ferr_nx  = 1'b1;
            state_nx = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (honours UART_RX_PARITY_EN)
// Drives frames like a transmitter and checks them against a timing/parity model.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] cycles_per_databit = 10'd50;
  logic       rx_line = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, frame_error, parity_error, rx_busy;

  uart_rx dut (
    .clk(clk),
    .resetn(resetn),
    .cycles_per_databit(cycles_per_databit),
    .rx_line(rx_line),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .frame_error(frame_error),
    .parity_error(parity_error),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] done_data[$];
  int         done_cyc[$];
  logic       done_busy[$];
  int         ferr_cyc[$];
  int         perr_cyc[$];

  always @(negedge clk) begin
    if (rx_done) begin
      done_data.push_back(rx_data);
      done_cyc.push_back(cyc);
      done_busy.push_back(rx_busy);
    end
    if (frame_error) ferr_cyc.push_back(cyc);
    if (parity_error) perr_cyc.push_back(cyc);
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_cpd(input int c);
    return (c < 4) ? 4 : c;
  endfunction

  // Cycles from the transmitter's start edge to the registered strobe.
  function automatic int exp_latency(input int cpd);
    return 3 + cpd / 2 + NBITS * cpd + 1;
  endfunction

  task automatic drive_bit(input logic b, input int n);
    rx_line = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stopb,
                            input int cpd, output int t0);
    @(posedge clk);
    #1;
    t0 = cyc;
    drive_bit(1'b0, cpd);
    for (int i = 0; i < 8; i++) drive_bit(b[i], cpd);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, cpd);
`else
    if (par === 1'bx) rx_line = 1'b0;
`endif
    drive_bit(stopb, cpd);
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [7:0] b,
                             input int t0, input int cpd);
    check({tag, " done"}, 32'(done_data.size() > idx), 32'd1);
    if (done_data.size() > idx) begin
      check({tag, " data"}, 32'(done_data[idx]), 32'(b));
      check({tag, " latency"}, 32'(done_cyc[idx] - t0), 32'(exp_latency(cpd)));
      check({tag, " busy_fall"}, 32'(done_busy[idx]), 32'd0);
    end
  endtask

  initial begin
    int t0, t1, base, fbase, pbase, c_in, c, rise, fall;
    logic [7:0] b;
    logic par;

    repeat (3) @(posedge clk);
    #1;
    check("rst rx_data", 32'(rx_data), 32'h00);
    check("rst rx_done", 32'(rx_done), 32'd0);
    check("rst frame_error", 32'(frame_error), 32'd0);
    check("rst parity_error", 32'(parity_error), 32'd0);
    check("rst rx_busy", 32'(rx_busy), 32'd0);
    resetn = 1'b1;
    drive_bit(1'b1, 10);

    // back-to-back 0x00, 0x01
    cycles_per_databit = 10'd50;
    base = done_data.size(); fbase = ferr_cyc.size(); pbase = perr_cyc.size();
    send_frame(8'h00, 1'b0, 1'b1, 50, t0);
    send_frame(8'h01, 1'b1, 1'b1, 50, t1);
    drive_bit(1'b1, 60);
    check_frame("basic0", base, 8'h00, t0, 50);
    check_frame("basic1", base + 1, 8'h01, t1, 50);
    check("basic count", 32'(done_data.size() - base), 32'd2);
    check("basic ferr", 32'(ferr_cyc.size() - fbase), 32'd0);
    check("basic perr", 32'(perr_cyc.size() - pbase), 32'd0);

    base = done_data.size();
    send_frame(8'hA5, 1'b0, 1'b1, 50, t0);
    drive_bit(1'b1, 60);
    check_frame("a5", base, 8'hA5, t0, 50);

    for (int k = 0; k < 8; k++) begin
      c_in = $urandom_range(0, 24);
      c = eff_cpd(c_in);
      b = 8'($urandom);
      par = 1'($urandom);
      cycles_per_databit = 10'(c_in);
      base = done_data.size(); fbase = ferr_cyc.size(); pbase = perr_cyc.size();
      send_frame(b, par, 1'b1, c, t0);
      cycles_per_databit = 10'($urandom_range(0, 1023));
      drive_bit(1'b1, c + 8);
      check_frame($sformatf("rand%0d cpd%0d", k, c_in), base, b, t0, c);
      check("rand ferr", 32'(ferr_cyc.size() - fbase), 32'd0);
`ifdef UART_RX_PARITY_EN
      check("rand perr", 32'(perr_cyc.size() - pbase), 32'(par != ^b));
`else
      check("rand perr", 32'(perr_cyc.size() - pbase), 32'd0);
`endif
    end

    // glitch: 10 low cycles at cpd=50
    cycles_per_databit = 10'd50;
    drive_bit(1'b1, 10);
    base = done_data.size(); fbase = ferr_cyc.size();
    rise = -1; fall = -1;
    @(posedge clk);
    #1;
    rx_line = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) rx_line = 1'b1;
      if (rx_busy && rise < 0) rise = k;
      if (!rx_busy && rise >= 0 && fall < 0) fall = k;
    end
    check("glitch busy_rise", 32'(rise), 32'd3);
    check("glitch busy_fall", 32'(fall), 32'(4 + 50 / 2));
    check("glitch no done", 32'(done_data.size() - base), 32'd0);
    check("glitch no ferr", 32'(ferr_cyc.size() - fbase), 32'd0);

    // framing error followed by a held-low line
    base = done_data.size(); fbase = ferr_cyc.size(); pbase = perr_cyc.size();
    send_frame(8'h3C, 1'b0, 1'b0, 50, t0);
    drive_bit(1'b0, 200);
    check("ferr count", 32'(ferr_cyc.size() - fbase), 32'd1);
    if (ferr_cyc.size() > fbase)
      check("ferr latency", 32'(ferr_cyc[fbase] - t0), 32'(exp_latency(50)));
    check("ferr rx_data", 32'(rx_data), 32'h3C);
    check("ferr no done", 32'(done_data.size() - base), 32'd0);
    check("ferr no perr", 32'(perr_cyc.size() - pbase), 32'd0);
    drive_bit(1'b1, 50);
    check("break busy", 32'(rx_busy), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 50, t0);
    drive_bit(1'b1, 60);
    check_frame("after_ferr", base, 8'h5A, t0, 50);

    // reset in the middle of data bit 4
    cycles_per_databit = 10'd20;
    base = done_data.size(); fbase = ferr_cyc.size();
    @(posedge clk);
    #1;
    drive_bit(1'b0, 20);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 20);
    drive_bit(1'b0, 10);
    check("pre-rst busy", 32'(rx_busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("midrst rx_data", 32'(rx_data), 32'h00);
    check("midrst rx_done", 32'(rx_done), 32'd0);
    check("midrst frame_error", 32'(frame_error), 32'd0);
    check("midrst parity_error", 32'(parity_error), 32'd0);
    check("midrst rx_busy", 32'(rx_busy), 32'd0);
    rx_line = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b1;
    drive_bit(1'b1, 300);
    check("midrst no strobe", 32'((done_data.size() - base) + (ferr_cyc.size() - fbase)), 32'd0);
    cycles_per_databit = 10'd50;
    send_frame(8'h81, 1'b0, 1'b1, 50, t0);
    drive_bit(1'b1, 60);
    check_frame("after_rst", base, 8'h81, t0, 50);

`ifdef UART_RX_PARITY_EN
    base = done_data.size(); pbase = perr_cyc.size();
    send_frame(8'h07, 1'b1, 1'b1, 50, t0);
    drive_bit(1'b1, 60);
    check_frame("par_ok", base, 8'h07, t0, 50);
    check("par_ok perr", 32'(perr_cyc.size() - pbase), 32'd0);
    send_frame(8'h07, 1'b0, 1'b1, 50, t0);
    drive_bit(1'b1, 60);
    check_frame("par_bad", base + 1, 8'h07, t0, 50);
    check("par_bad perr", 32'(perr_cyc.size() - pbase), 32'd1);
    if (perr_cyc.size() > pbase && done_cyc.size() > base + 1)
      check("par_bad same cycle", 32'(perr_cyc[pbase]), 32'(done_cyc[base + 1]));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
